instr_fetch_mem: RTL and testbench
==================================

# instr_fetch_mem

Parametrised, handshaked instruction memory for the processor front end, the next generation of the combinational instruction lookup. It accepts PC requests on a valid/ready port and returns the word-indexed instruction (PC >> 2) through a 2-entry response FIFO with one-cycle latency. It adds:
- a load port for programming the memory at run time,
- a synchronous flush for branch redirects,
- optional address-fault detection.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, PC width in bits
- DEPTH, 16, number of instruction words; power of two, at least 2
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridden)

Ports (clock and reset first):
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  fetch request present
- req_ready  output  1  block can accept a request this cycle
- req_pc  input  ADDR_W  byte address of the requested instruction
- rsp_valid  output  1  head of the response FIFO is valid
- rsp_ready  input  1  consumer takes the head entry this cycle
- rsp_instr  output  DATA_W  instruction at the FIFO head
- rsp_pc  output  ADDR_W  PC that produced rsp_instr
- rsp_fault  output  1  head entry is a faulted fetch (always 0 without IMEM_FAULT_EN)
- flush  input  1  discard all queued responses and any same-cycle request
- wr_en  input  1  write the instruction memory
- wr_addr  input  IDX_W  word index to write
- wr_data  input  DATA_W  word to write

## Operation
- Memory: DEPTH x DATA_W register array.
  - Not reset; contents are undefined until written.
  - wr_en writes mem[wr_addr] at the clock edge.
- Word index: idx = req_pc[IDX_W+1:2].
- Accept: a request is accepted when req_valid && req_ready.
  - In the accept cycle, {mem[idx], req_pc, fault} is pushed into the FIFO.
- Response FIFO:
  - 2 entries, circular read/write pointers plus a count of 0..2.
  - rsp_valid = (count != 0).
  - Outputs are driven from the head entry.
  - Pop on rsp_valid && rsp_ready.
- req_ready = rst_n && !flush && (count < 2).
  - No pass-through when full: a pop in a cycle with count == 2 does not open ready in that same cycle.
- Simultaneous push and pop with count == 1: count stays 1 and FIFO order is preserved.
- Read/write collision: wr_en to the same index as an accepted read returns the old word (read-before-write). The new word is visible from the next accept onward.
- Flush:
  - Sets count = 0 and pointers = 0 at the edge.
  - A pop in the flush cycle is ignored.
  - A request in the flush cycle is not accepted.
  - wr_en is unaffected by flush.
- Reset (async assert, sync deassert handled externally):
  - count = 0, pointers = 0.
  - rsp_valid = 0, rsp_instr = 0, rsp_pc = 0, rsp_fault = 0, req_ready = 0.
- Reset mid-operation discards all queued entries; memory contents are retained.
- Rule for the head-entry outputs: when count == 0, rsp_instr, rsp_pc and rsp_fault are driven to 0.

## Timing
- Latency is 1 cycle:
  - A request accepted at edge N yields rsp_valid = 1 after edge N (visible in cycle N+1), if the FIFO was empty.
- Throughput is 1 request per cycle while the consumer holds rsp_ready = 1.
- Back-pressure:
  - rsp_ready = 0 for two accepted requests gives count = 2 and req_ready = 0.
  - req_ready returns to 1 in the cycle after the first pop.
- The block does not retain or re-sample requests. The requester must hold req_valid and req_pc stable until accepted.
- After rst_n deasserts, req_ready = 1 from the first cycle with rst_n high and count == 0.

## Configuration
- Macro: IMEM_FAULT_EN.
- Defined:
  - fault = (req_pc[1:0] != 0) || (req_pc >> 2 >= DEPTH).
  - A faulted entry is still pushed in order, with rsp_instr = 0 and rsp_fault = 1.
- Undefined:
  - No fault logic; rsp_fault is tied to 0.
  - req_pc[1:0] is ignored and the index wraps modulo DEPTH, so PC 0x44 reads mem[1] when DEPTH = 16.

## Test plan
- Program mem[0..3] = 0xA0..0xA3, then request PCs 0x0, 0x4, 0x8, 0xC back-to-back with rsp_ready = 1 -> rsp_instr = 0xA0..0xA3 in consecutive cycles, starting 1 cycle after the first accept.
- rsp_ready = 0 while requesting 0x0, 0x4, 0x8 -> only 2 accepts and req_ready = 0. Then assert rsp_ready -> 0xA0 and 0xA1 pop in order, and 0x8 is accepted in the cycle after the first pop.
- Two entries queued, then flush = 1 with req_valid = 1 -> next cycle rsp_valid = 0 and the flush-cycle request is not accepted.
- wr_en mem[2] = 0xBB in the same cycle as an accepted request to PC 0x8 (old value 0xA2) -> response 0xA2. The next request to 0x8 returns 0xBB.
- IMEM_FAULT_EN defined: request PC 0x2 and PC 0x40 (DEPTH = 16) -> two responses, each with rsp_fault = 1 and rsp_instr = 0. Macro undefined: PC 0x40 returns mem[0] with rsp_fault = 0.
- Assert rst_n = 0 with 2 entries queued -> rsp_valid = 0 and req_ready = 0 immediately (asynchronously). After release, a request to 0x4 returns the preserved mem[1].

Source files
------------

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: run-time loadable instruction memory behind a valid/ready port, with a 2-entry response FIFO.
// Define IMEM_FAULT_EN to flag misaligned or out-of-range PCs as faulted fetches.
module instr_fetch_mem #(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 32,
   parameter  int DEPTH  = 16,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_pc,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [ADDR_W-1:0] rsp_pc,
   output logic              rsp_fault,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
      logic              fault;
   } rsp_ent_t;

   // Instruction store: deliberately not reset so a reset keeps the loaded program.
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   logic [IDX_W-1:0] rd_idx;
   logic             rd_fault;
   rsp_ent_t         push_ent;

   assign rd_idx = req_pc[IDX_W+1:2];

`ifdef IMEM_FAULT_EN
   logic [ADDR_W-1:0] word_addr;
   assign word_addr = req_pc >> 2;
   assign rd_fault  = (req_pc[1:0] != 2'b00) || (word_addr >= ADDR_W'(DEPTH));
`else
   assign rd_fault  = 1'b0;
`endif

   // The read happens in the accept cycle, so a same-cycle write is seen only by later accepts.
   always_comb begin
      push_ent.instr = rd_fault ? '0 : mem_q[rd_idx];
      push_ent.pc    = req_pc;
      push_ent.fault = rd_fault;
   end

   rsp_ent_t   ent_q [2];
   logic [1:0] cnt_q, cnt_d;
   logic       rptr_q, rptr_d;
   logic       wptr_q, wptr_d;
   logic       push, pop;

   // No pass-through: readiness depends only on the registered count.
   assign req_ready = rst_n && !flush && (cnt_q != 2'd2);
   assign push      = req_valid && req_ready;
   assign pop       = (cnt_q != 2'd0) && rsp_ready && !flush;

   always_comb begin
      cnt_d  = cnt_q;
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      if (flush) begin
         cnt_d  = 2'd0;
         rptr_d = 1'b0;
         wptr_d = 1'b0;
      end else begin
         if (push) wptr_d = ~wptr_q;
         if (pop)  rptr_d = ~rptr_q;
         cnt_d = cnt_q + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         rptr_q <= 1'b0;
         wptr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) ent_q[i] <= '0;
      end else if (push) begin
         ent_q[wptr_q] <= push_ent;
      end
   end

   rsp_ent_t head;

   // An empty FIFO presents all-zero head fields rather than stale entries.
   assign head      = (cnt_q != 2'd0) ? ent_q[rptr_q] : '0;
   assign rsp_valid = (cnt_q != 2'd0);
   assign rsp_instr = head.instr;
   assign rsp_pc    = head.pc;
   assign rsp_fault = head.fault;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Randomised self-checking bench for instr_fetch_mem against a queue-based reference model.
module tb_instr_fetch_mem;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_pc;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_instr;
   logic [ADDR_W-1:0] rsp_pc;
   logic              rsp_fault;
   logic              flush;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [DATA_W-1:0] wr_data;

   always #5 clk = ~clk;

   instr_fetch_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
      .rsp_pc(rsp_pc), .rsp_fault(rsp_fault), .flush(flush),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } m_ent_t;

   logic [31:0] mmem [DEPTH];
   m_ent_t      q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   // {req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault}
   logic [66:0] obs, expv;
   logic        last_acc;

   function automatic m_ent_t model_fetch(logic [31:0] pc);
      m_ent_t e;
      e.pc    = pc;
      e.fault = 1'b0;
`ifdef IMEM_FAULT_EN
      e.fault = (pc % 4 != 0) || (pc / 4 >= DEPTH);
`endif
      e.instr = e.fault ? 32'h0 : mmem[(pc / 4) % DEPTH];
      return e;
   endfunction

   // One clock: sample DUT and model at the falling edge, advance the model at the rising edge.
   task automatic tick();
      m_ent_t head, nxt;
      logic   m_ready, pop;
      @(negedge clk);
      if (!rst_n) q.delete();
      obs     = {req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault};
      m_ready = rst_n && !flush && (q.size() < 2);
      head    = (q.size() != 0) ? q[0] : '0;
      expv    = {m_ready, (q.size() != 0), head};
      nxt     = model_fetch(req_pc);
      last_acc = req_valid && m_ready;
      pop     = (q.size() != 0) && rsp_ready && !flush;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (last_acc) q.push_back(nxt);
      end
      if (wr_en) mmem[wr_addr] = wr_data;
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0;
      req_pc    = '0;
      flush     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rsp_ready = 1'b0;
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
         end
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (obs[66:65] !== 2'b10) begin
         n_fail++;
         $display("FAIL ready_after_reset: got ready/valid %b expected 10", obs[66:65]);
      end
   endtask

   task automatic test_load();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en   = 1'b1;
         wr_addr = IDX_W'(i);
         wr_data = (i < 4) ? 32'hA0 + 32'(i) : $urandom;
         tick();
         n_checks++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL load_idle: got %h expected %h", obs, expv);
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         req_valid = (k < 4);
         req_pc    = 32'(k) * 4;
         tick();
         n_checks++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL b2b_model k=%0d: got %h expected %h", k, obs, expv);
         end
         if (k >= 1 && k <= 4) begin
            n_checks++;
            if (obs[65] !== 1'b1 || obs[64:33] !== 32'hA0 + 32'(k - 1)) begin
               n_fail++;
               $display("FAIL b2b_instr k=%0d: got valid %b instr %h expected valid 1 instr %h",
                        k, obs[65], obs[64:33], 32'hA0 + 32'(k - 1));
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      logic [31:0] pcs [3];
      int p;
      pcs = '{32'h0, 32'h4, 32'h8};
      p = 0;
      for (int t = 0; t < 8; t++) begin
         req_valid = (p < 3);
         if (p < 3) req_pc = pcs[p];
         rsp_ready = (t >= 4);
         tick();
         if (last_acc) p++;
         n_checks++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL bp_model t=%0d: got %h expected %h", t, obs, expv);
         end
         if (t >= 2 && t <= 4) begin
            n_checks++;
            if (obs[66] !== 1'b0 || obs[65] !== 1'b1 || obs[64:33] !== 32'hA0) begin
               n_fail++;
               $display("FAIL bp_full t=%0d: got ready %b valid %b instr %h expected 0 1 a0",
                        t, obs[66], obs[65], obs[64:33]);
            end
         end
         if (t == 5) begin
            n_checks++;
            if (obs[66] !== 1'b1 || obs[64:33] !== 32'hA1) begin
               n_fail++;
               $display("FAIL bp_reopen: got ready %b instr %h expected 1 a1", obs[66], obs[64:33]);
            end
         end
         if (t == 6) begin
            n_checks++;
            if (obs[64:33] !== 32'hA2 || obs[32:1] !== 32'h8) begin
               n_fail++;
               $display("FAIL bp_third: got instr %h pc %h expected a2 8", obs[64:33], obs[32:1]);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_pc = 32'hC;
      tick();
      req_pc = 32'h0;
      tick();
      flush = 1'b1;
      req_pc = 32'h4;
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (obs[66] !== 1'b0 || obs[65] !== 1'b1 || obs[64:33] !== 32'hA3) begin
         n_fail++;
         $display("FAIL flush_cycle: got ready %b valid %b instr %h expected 0 1 a3",
                  obs[66], obs[65], obs[64:33]);
      end
      flush = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (obs !== expv || obs[66:65] !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_empty i=%0d: got %h expected %h", i, obs, expv);
         end
      end
      idle_inputs();
   endtask

   task automatic test_collision();
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_pc  = 32'h8;
      wr_en   = 1'b1;
      wr_addr = 4'd2;
      wr_data = 32'hBB;
      tick();
      wr_en = 1'b0;
      tick();
      n_checks++;
      if (obs !== expv || obs[64:33] !== 32'hA2) begin
         n_fail++;
         $display("FAIL collision_old: got %h expected instr a2 (%h)", obs, expv);
      end
      req_valid = 1'b0;
      tick();
      n_checks++;
      if (obs !== expv || obs[64:33] !== 32'hBB) begin
         n_fail++;
         $display("FAIL collision_new: got %h expected instr bb (%h)", obs, expv);
      end
      idle_inputs();
   endtask

   task automatic test_fault();
      logic [64:0] e0, e1;
`ifdef IMEM_FAULT_EN
      e0 = {32'h0, 32'h2, 1'b1};
      e1 = {32'h0, 32'h40, 1'b1};
`else
      e0 = {32'hA0, 32'h2, 1'b0};
      e1 = {32'hA0, 32'h40, 1'b0};
`endif
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_pc = 32'h2;
      tick();
      req_pc = 32'h40;
      tick();
      n_checks++;
      if (obs[64:0] !== e0 || obs[65] !== 1'b1) begin
         n_fail++;
         $display("FAIL fault_pc2: got %h expected %h", obs[64:0], e0);
      end
      req_valid = 1'b0;
      tick();
      n_checks++;
      if (obs[64:0] !== e1 || obs[65] !== 1'b1) begin
         n_fail++;
         $display("FAIL fault_pc40: got %h expected %h", obs[64:0], e1);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (!(req_valid && !last_acc)) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_pc = ($urandom_range(0, 3) == 0) ? $urandom
                                                 : 32'($urandom_range(0, DEPTH - 1)) << 2;
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         wr_en     = ($urandom_range(0, 4) == 0);
         wr_addr   = IDX_W'($urandom_range(0, DEPTH - 1));
         wr_data   = $urandom;
         tick();
         n_checks++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL random_model i=%0d: got %h expected %h", i, obs, expv);
         end
      end
      idle_inputs();
      rsp_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 4'd1;
      wr_data = 32'h5A5A_0001;
      tick();
      wr_en = 1'b0;
      req_valid = 1'b1;
      req_pc = 32'h0;
      tick();
      req_pc = 32'hC;
      tick();
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_instr !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got valid %b ready %b instr %h expected 0 0 0",
                  rsp_valid, req_ready, rsp_instr);
      end
      tick();
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_held: got %h expected 0", obs);
      end
      rst_n = 1'b1;
      req_valid = 1'b1;
      req_pc = 32'h4;
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (obs !== expv || obs[66:65] !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected %h", obs, expv);
      end
      req_valid = 1'b0;
      tick();
      n_checks++;
      if (obs[65] !== 1'b1 || obs[64:33] !== 32'h5A5A_0001) begin
         n_fail++;
         $display("FAIL reset_mem_kept: got valid %b instr %h expected 1 5a5a0001",
                  obs[65], obs[64:33]);
      end
      idle_inputs();
   endtask

   initial begin
      last_acc = 1'b0;
      test_reset();
      test_load();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_collision();
      test_fault();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
